// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the multi-cycle RV32I control unit
package riscv_pkg;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECUTER = 4'd6, S_ALUWB = 4'd7,
    S_EXECUTEI = 4'd8, S_JAL = 4'd9, S_BEQ = 4'd10
  } state_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp plus funct3/funct7b5/op[5] to ALUControl
// ports: i_aluop, i_funct3, i_funct7b5, i_op5 -> o_alu_control
module alu_decoder
  import riscv_pkg::*;
(
  input  aluop_t     i_aluop,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);
  logic [2:0] w_funct;
  // op[5] separates R-type from I-type so addi never decodes as sub
  assign w_funct = i_funct3 == 3'b000 ? ((i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD) :
                   i_funct3 == 3'b010 ? ALU_SLT :
                   i_funct3 == 3'b110 ? ALU_OR  :
                   i_funct3 == 3'b111 ? ALU_AND : ALU_ADD;
  assign o_alu_control = i_aluop == ALUOP_SUB   ? ALU_SUB :
                         i_aluop == ALUOP_FUNCT ? w_funct : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore main FSM and decode for the multi-cycle RV32I datapath
// ports: clk, reset, op, funct3, funct7b5, zero (+ mem_ready with MEM_WAIT_EN) -> datapath selects/enables, state
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic [3:0] state
);
  state_t r_state, w_state, w_next;
  aluop_t w_aluop;
  logic w_ready, w_pc_update, w_branch, w_mem_write, w_ir_write, w_reg_write;
`ifdef MEM_WAIT_EN
  assign w_ready = mem_ready;
`else
  assign w_ready = 1'b1;
`endif
  // reset presents FETCH on every output without waiting for the edge
  assign w_state = reset ? S_FETCH : r_state;
  always_ff @(posedge clk)
    r_state <= reset ? S_FETCH : w_next;
  always_comb begin
    w_next      = S_FETCH;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    w_aluop     = ALUOP_ADD;
    case (w_state)
      S_FETCH: begin
        w_next      = w_ready ? S_DECODE : S_FETCH;
        w_ir_write  = w_ready;
        w_pc_update = w_ready;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        w_next  = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                  op == OP_R   ? S_EXECUTER :
                  op == OP_I   ? S_EXECUTEI :
                  op == OP_JAL ? S_JAL :
                  op == OP_BEQ ? S_BEQ : S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        w_next  = op == OP_SW ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = w_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
        w_next      = w_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_JAL: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA  = SRCA_RD1;
        w_aluop  = ALUOP_SUB;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end
  alu_decoder u_alu_decoder (
    .i_aluop       (w_aluop),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op5         (op[5]),
    .o_alu_control (ALUControl)
  );
  assign ImmSrc   = (op == OP_LW || op == OP_I) ? IMM_I :
                    op == OP_SW  ? IMM_S :
                    op == OP_BEQ ? IMM_B :
                    op == OP_JAL ? IMM_J : IMM_I;
  assign PCWrite  = ~reset & (w_pc_update | (w_branch & zero));
  assign MemWrite = ~reset & w_mem_write;
  assign IRWrite  = ~reset & w_ir_write;
  assign RegWrite = ~reset & w_reg_write;
  assign state    = w_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized self-checking bench against a table-driven instruction model
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1, funct7b5 = 1'b0, zero = 1'b0;
  logic [6:0] op = 7'b1111111;
  logic [2:0] funct3 = 3'd0;
`ifdef MEM_WAIT_EN
  logic mem_ready = 1'b1;
`endif
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  int n_pass = 0, n_total = 0;
  int exp_seq[$];
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] got_vec();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] exp_vec(input int s, input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
    logic [1:0] res = 0, sa = 0, sb = 0, imm;
    logic [2:0] alu = 0;
    imm = (o == LW || o == IT) ? 2'd0 : o == SW ? 2'd1 : o == BQ ? 2'd2 : o == JL ? 2'd3 : 2'd0;
    case (s)
      0:  begin irw = 1; sb = 2; res = 2; pcw = 1; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin res = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; alu = funct_alu(o, f3, f7); end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; alu = funct_alu(o, f3, f7); end
      9:  begin sa = 1; sb = 2; pcw = 1; end
      10: begin sa = 2; alu = 3'b001; pcw = z; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, res, sa, sb, imm, alu, rw};
  endfunction

  task automatic build_seq(input logic [6:0] o);
    exp_seq = {0, 1};
    case (o)
      LW: exp_seq = {exp_seq, 2, 3, 4};
      SW: exp_seq = {exp_seq, 2, 5};
      RT: exp_seq = {exp_seq, 6, 7};
      IT: exp_seq = {exp_seq, 8, 7};
      JL: exp_seq = {exp_seq, 9, 7};
      BQ: exp_seq = {exp_seq, 10};
      default: ;
    endcase
  endtask

  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    logic [15:0] e;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    build_seq(o);
    foreach (exp_seq[i]) begin
      @(negedge clk);
      n_total++;
      if (state !== 4'(exp_seq[i])) $display("FAIL %s state step %0d: got %0d want %0d", name, i, state, exp_seq[i]);
      else n_pass++;
      e = exp_vec(exp_seq[i], o, f3, f7, z);
      n_total++;
      if (got_vec() !== e) $display("FAIL %s outputs in state %0d: got %h want %h", name, exp_seq[i], got_vec(), e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_total++;
      if ({state, IRWrite, PCWrite, MemWrite, RegWrite, ALUSrcB, ResultSrc} !== {4'd0, 4'b0000, 2'b10, 2'b10})
        $display("FAIL reset_hold: got st=%0d ir=%b pc=%b mw=%b rw=%b", state, IRWrite, PCWrite, MemWrite, RegWrite);
      else n_pass++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    op = 7'b1111111;
    @(negedge clk);
    n_total++;
    if ({state, IRWrite, PCWrite} !== {4'd0, 2'b11}) $display("FAIL reset_release: got st=%0d ir=%b pc=%b want 0 1 1", state, IRWrite, PCWrite);
    else n_pass++;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_abort();
    op = LW;
    repeat (4) begin @(posedge clk); #1; end
    n_total++;
    if (state !== 4'd4) $display("FAIL abort_setup: got st=%0d want 4", state);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({state, RegWrite, IRWrite, PCWrite, MemWrite} !== 8'h00) $display("FAIL abort_mask: got st=%0d rw=%b ir=%b pc=%b mw=%b", state, RegWrite, IRWrite, PCWrite, MemWrite);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr("after_abort", RT, 3'b110, 1'b0, 1'b0);
  endtask

  task automatic test_directed();
    run_instr("lw", LW, 3'b010, 1'b0, 1'b0);
    run_instr("sw", SW, 3'b010, 1'b0, 1'b1);
    run_instr("r_sub", RT, 3'b000, 1'b1, 1'b0);
    run_instr("addi_f7", IT, 3'b000, 1'b1, 1'b0);
    run_instr("r_slt", RT, 3'b010, 1'b0, 1'b0);
    run_instr("r_and", RT, 3'b111, 1'b0, 1'b0);
    run_instr("beq_taken", BQ, 3'b000, 1'b0, 1'b1);
    run_instr("beq_not", BQ, 3'b000, 1'b0, 1'b0);
    run_instr("jal", JL, 3'b101, 1'b1, 1'b1);
    run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [6:0] ops[6] = '{LW, SW, RT, IT, BQ, JL};
    logic [6:0] o;
    for (int k = 0; k < 150; k++) begin
      int idx = $urandom_range(0, 6);
      if (idx < 6) o = ops[idx];
      else begin
        o = 7'($urandom);
        while (o inside {LW, SW, RT, IT, BQ, JL}) o = 7'($urandom);
      end
      run_instr("random", o, 3'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_total++;
      if ({state, IRWrite, PCWrite} !== 6'b0) $display("FAIL fetch_wait: got st=%0d ir=%b pc=%b", state, IRWrite, PCWrite);
      else n_pass++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    run_instr("after_wait", LW, 3'b010, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
`ifdef MEM_WAIT_EN
    test_mem_wait();
`endif
    test_reset_abort();
    test_random();
    @(negedge clk);
    n_total++;
    if (state !== 4'd0) $display("FAIL final_fetch: got %0d want 0", state);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
